dl_sequencer: RTL and testbench
===============================

# dl_sequencer

Download sequencer between the HPS ioctl stream and the arcade core. It routes ROM bytes (index 0) to the core's download port through a one-cycle pipeline and latches the game-variant byte (index 1) and the eight DIP-switch bytes (index 254). It holds the core in reset for the whole download and for a fixed settle period afterwards, and it reports ROM length, a 16-bit checksum and overflow status for on-screen diagnostics.

## Interface
- ROM_SIZE, 16'hC000: highest accepted ROM byte count. Index-0 addresses at or above this value are dropped.
- HOLD_CYCLES, 1024: number of clk_sys cycles that core_reset stays asserted after download ends. Must be at least 1.
- clk_sys  in  1  system clock; all logic is on its rising edge.
- RESET_N  in  1  asynchronous, active-low reset.
- ioctl_download  in  1  high for the duration of one download.
- ioctl_index  in  8  download target: 0 = ROM, 1 = variant, 254 = DIP switches; all other values are ignored.
- ioctl_wr  in  1  single-cycle byte strobe.
- ioctl_addr  in  25  byte address within the current download.
- ioctl_dout  in  8  byte data.
- dn_wr  out  1  write strobe to the core.
- dn_addr  out  16  ROM byte address to the core.
- dn_data  out  8  ROM byte data to the core.
- mod  out  8  latched variant number.
- mod_valid  out  1  high once a variant byte has been latched.
- sw  out  64  DIP bytes; byte n is sw[8n+7:8n].
- core_reset  out  1  active-high reset for the core.
- busy  out  1  high in any state other than IDLE.
- rom_len  out  17  count of accepted ROM bytes.
- rom_sum  out  16  modulo-2^16 sum of accepted ROM bytes.
- overflow  out  1  sticky flag: a ROM byte was dropped.

## Operation
- States: IDLE, ROM, VAR, DIP, HOLD.
- Leaving IDLE: when ioctl_download rises, the FSM enters ROM, VAR or DIP according to ioctl_index. Any other index enters HOLD with no capture.
- Entering ROM clears rom_len, rom_sum and overflow.
- Leaving ROM, VAR or DIP: when ioctl_download falls, the FSM enters HOLD and loads hold_cnt = HOLD_CYCLES-1.
- HOLD: hold_cnt decrements each cycle. When it reaches 0, the FSM returns to IDLE.
- Restart from HOLD: if ioctl_download rises during HOLD, the FSM leaves HOLD immediately for the state selected by the new index. The hold counter restarts on the next fall.
- ioctl_index is sampled only on the rising edge of ioctl_download. Changes to it mid-download are ignored.
- ROM state, per ioctl_wr:
  - Accepted when ioctl_addr < ROM_SIZE. The byte passes to dn_* with dn_addr = ioctl_addr[15:0]. rom_len becomes max(rom_len, addr+1). rom_sum += dout, zero-extended and wrapping.
  - Otherwise the byte is dropped: no dn_wr, and overflow is set.
- VAR state: ioctl_wr with addr == 0 loads mod and sets mod_valid. Writes at other addresses are ignored.
- DIP state: ioctl_wr with addr < 8 writes byte addr[2:0] of sw. Writes at higher addresses are ignored.
- core_reset is high in every state except IDLE.
- Outside ROM state, dn_wr stays 0 whatever ioctl_wr does.

## Timing
- Reset values:
  - FSM is in HOLD with hold_cnt = HOLD_CYCLES-1, so core_reset = 1 and busy = 1 after reset.
  - dn_wr = 0, dn_addr = 0, dn_data = 0.
  - mod = 0, mod_valid = 0.
  - sw = all ones.
  - rom_len = 0, rom_sum = 0, overflow = 0.
- Pipeline latency: an ioctl_wr sampled at edge k produces dn_wr/dn_addr/dn_data valid on the cycle after edge k, for exactly one cycle. Back-to-back strobes give back-to-back dn_wr.
- rom_sum and rom_len update on the same edge that registers dn_wr.
- State transitions take effect on the edge where the level change of ioctl_download is sampled. There is no synchronizer; the source is already on clk_sys.
- Strobe on the falling-edge cycle: if ioctl_wr and the falling edge of ioctl_download are sampled together, the byte is still processed.
- core_reset deasserts HOLD_CYCLES cycles after the edge at which the fall was sampled.
- RESET_N asserted mid-download: all registers go to their reset values immediately. A download still in progress is ignored until ioctl_download falls and rises again.

## Test plan
- Reset: release RESET_N with HOLD_CYCLES=4 and ioctl_download low -> core_reset high for 4 cycles then low; sw = 64'hFFFF_FFFF_FFFF_FFFF; busy follows core_reset.
- ROM stream: index 0, bytes 0x01,0x02,0xFF at addr 0..2 -> dn_wr pulses one cycle after each strobe with the matching addr/data; rom_len = 3; rom_sum = 0x0102; core_reset high throughout and for HOLD_CYCLES after the fall.
- Overflow: ROM_SIZE = 16'hC000, write addr 0xC000 data 0x55 -> no dn_wr; overflow = 1; rom_sum and rom_len unchanged. A new index-0 download clears overflow.
- Variant and DIP: index 1, addr 0 data 0x0B -> mod = 0x0B, mod_valid = 1. Index 254, addr 3 data 0x5A and addr 9 data 0x00 -> sw[31:24] = 0x5A, all other bytes still 0xFF.
- Re-trigger in HOLD: start an index-254 download 2 cycles into HOLD -> FSM enters DIP; core_reset stays high with no gap; full HOLD_CYCLES hold after the new fall.
- Reset mid-ROM: assert RESET_N low after 2 ROM bytes -> rom_len = 0, dn_wr = 0, core_reset = 1 immediately. Further strobes in the same download produce no dn_wr.

Source files
------------

// File: rtl/dl_sequencer.sv
// dl_sequencer: routes HPS ioctl downloads to the arcade core (ROM, variant, DIP bytes)
// and holds the core in reset during and for HOLD_CYCLES after each download.
`default_nettype none

module dl_sequencer #(
    parameter logic [15:0] ROM_SIZE    = 16'hC000,
    parameter int unsigned HOLD_CYCLES = 1024
) (
    input  logic        clk_sys,
    input  logic        RESET_N,
    input  logic        ioctl_download,
    input  logic [7:0]  ioctl_index,
    input  logic        ioctl_wr,
    input  logic [24:0] ioctl_addr,
    input  logic [7:0]  ioctl_dout,
    output logic        dn_wr,
    output logic [15:0] dn_addr,
    output logic [7:0]  dn_data,
    output logic [7:0]  mod,
    output logic        mod_valid,
    output logic [63:0] sw,
    output logic        core_reset,
    output logic        busy,
    output logic [16:0] rom_len,
    output logic [15:0] rom_sum,
    output logic        overflow
);

    localparam int unsigned     CNT_W     = $clog2(HOLD_CYCLES + 1);
    localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_ROM  = 3'd1,
        S_VAR  = 3'd2,
        S_DIP  = 3'd3,
        S_HOLD = 3'd4
    } state_t;

    state_t           state_q;
    state_t           entry_state_d;
    logic [CNT_W-1:0] hold_cnt_q;
    logic             dl_prev_q;
    logic             dn_wr_q;
    logic [15:0]      dn_addr_q;
    logic [7:0]       dn_data_q;
    logic [7:0]       mod_q;
    logic             mod_valid_q;
    logic [63:0]      sw_q;
    logic [16:0]      rom_len_q;
    logic [15:0]      rom_sum_q;
    logic             overflow_q;

    logic             dl_rise;
    logic             dl_fall;
    logic             rom_accept;
    logic [16:0]      addr_inc;

    assign dl_rise    = ioctl_download & ~dl_prev_q;
    assign dl_fall    = ~ioctl_download & dl_prev_q;
    assign rom_accept = (ioctl_addr < {9'd0, ROM_SIZE});
    assign addr_inc   = {1'b0, ioctl_addr[15:0]} + 17'd1;

    always_comb begin
        entry_state_d = S_HOLD;
        case (ioctl_index)
            8'd0:    entry_state_d = S_ROM;
            8'd1:    entry_state_d = S_VAR;
            8'd254:  entry_state_d = S_DIP;
            default: entry_state_d = S_HOLD;
        endcase
    end

    // dl_prev_q resets high so a download already in progress at reset
    // cannot be mistaken for a fresh rising edge.
    always_ff @(posedge clk_sys or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q     <= S_HOLD;
            hold_cnt_q  <= HOLD_LOAD;
            dl_prev_q   <= 1'b1;
            dn_wr_q     <= 1'b0;
            dn_addr_q   <= 16'd0;
            dn_data_q   <= 8'd0;
            mod_q       <= 8'd0;
            mod_valid_q <= 1'b0;
            sw_q        <= {64{1'b1}};
            rom_len_q   <= 17'd0;
            rom_sum_q   <= 16'd0;
            overflow_q  <= 1'b0;
        end else begin
            dl_prev_q <= ioctl_download;
            dn_wr_q   <= 1'b0;

            if (dl_rise && (state_q == S_IDLE || state_q == S_HOLD)) begin
                state_q    <= entry_state_d;
                hold_cnt_q <= HOLD_LOAD;
                if (entry_state_d == S_ROM) begin
                    rom_len_q  <= 17'd0;
                    rom_sum_q  <= 16'd0;
                    overflow_q <= 1'b0;
                end
            end else begin
                case (state_q)
                    S_ROM, S_VAR, S_DIP: begin
                        if (dl_fall) begin
                            state_q    <= S_HOLD;
                            hold_cnt_q <= HOLD_LOAD;
                        end
                    end
                    S_HOLD: begin
                        if (hold_cnt_q == '0) state_q <= S_IDLE;
                        else                  hold_cnt_q <= hold_cnt_q - CNT_W'(1);
                    end
                    default: ;
                endcase
            end

            // Byte capture keys on the current state, so a strobe that
            // coincides with the falling edge is still processed.
            if (state_q == S_ROM && ioctl_wr) begin
                if (rom_accept) begin
                    dn_wr_q   <= 1'b1;
                    dn_addr_q <= ioctl_addr[15:0];
                    dn_data_q <= ioctl_dout;
                    rom_sum_q <= rom_sum_q + {8'd0, ioctl_dout};
                    if (addr_inc > rom_len_q) rom_len_q <= addr_inc;
                end else begin
                    overflow_q <= 1'b1;
                end
            end

            if (state_q == S_VAR && ioctl_wr && ioctl_addr == 25'd0) begin
                mod_q       <= ioctl_dout;
                mod_valid_q <= 1'b1;
            end

            if (state_q == S_DIP && ioctl_wr && ioctl_addr < 25'd8) begin
                sw_q[{ioctl_addr[2:0], 3'b000} +: 8] <= ioctl_dout;
            end
        end
    end

    assign dn_wr      = dn_wr_q;
    assign dn_addr    = dn_addr_q;
    assign dn_data    = dn_data_q;
    assign mod        = mod_q;
    assign mod_valid  = mod_valid_q;
    assign sw         = sw_q;
    assign core_reset = (state_q != S_IDLE);
    assign busy       = (state_q != S_IDLE);
    assign rom_len    = rom_len_q;
    assign rom_sum    = rom_sum_q;
    assign overflow   = overflow_q;

endmodule

`default_nettype wire

// File: tb/tb_dl_sequencer.sv
// tb_dl_sequencer: scoreboard bench for dl_sequencer; expected ROM writes are queued
// when strobes are driven and compared when dn_wr appears.
`default_nettype none

module tb_dl_sequencer;

    localparam int unsigned HOLD = 4;

    logic        clk_sys = 1'b0;
    logic        RESET_N;
    logic        ioctl_download;
    logic [7:0]  ioctl_index;
    logic        ioctl_wr;
    logic [24:0] ioctl_addr;
    logic [7:0]  ioctl_dout;
    logic        dn_wr;
    logic [15:0] dn_addr;
    logic [7:0]  dn_data;
    logic [7:0]  mod;
    logic        mod_valid;
    logic [63:0] sw;
    logic        core_reset;
    logic        busy;
    logic [16:0] rom_len;
    logic [15:0] rom_sum;
    logic        overflow;

    dl_sequencer #(
        .ROM_SIZE   (16'hC000),
        .HOLD_CYCLES(HOLD)
    ) dut (
        .clk_sys       (clk_sys),
        .RESET_N       (RESET_N),
        .ioctl_download(ioctl_download),
        .ioctl_index   (ioctl_index),
        .ioctl_wr      (ioctl_wr),
        .ioctl_addr    (ioctl_addr),
        .ioctl_dout    (ioctl_dout),
        .dn_wr         (dn_wr),
        .dn_addr       (dn_addr),
        .dn_data       (dn_data),
        .mod           (mod),
        .mod_valid     (mod_valid),
        .sw            (sw),
        .core_reset    (core_reset),
        .busy          (busy),
        .rom_len       (rom_len),
        .rom_sum       (rom_sum),
        .overflow      (overflow)
    );

    always #5 clk_sys = ~clk_sys;

    typedef struct {
        logic [15:0] addr;
        logic [7:0]  data;
        int unsigned cyc;
    } exp_t;

    exp_t        sb_q[$];
    int unsigned cyc = 0;
    int unsigned n_checks = 0;
    int unsigned n_fail = 0;

    always @(posedge clk_sys) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    always @(negedge clk_sys) begin
        if (dn_wr === 1'b1) begin
            if (sb_q.size() == 0) begin
                check_eq("dn_wr_spurious", 64'(dn_wr), 64'd0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check_eq("dn_addr", 64'(dn_addr), 64'(e.addr));
                check_eq("dn_data", 64'(dn_data), 64'(e.data));
                check_eq("dn_cycle", 64'(cyc), 64'(e.cyc));
            end
        end
    end

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic start_dl(input logic [7:0] idx);
        ioctl_index    = idx;
        ioctl_download = 1'b1;
        tick();
    endtask

    task automatic end_dl();
        ioctl_download = 1'b0;
        tick();
    endtask

    task automatic wr_byte(input logic [24:0] a, input logic [7:0] d, input bit accept);
        exp_t e;
        ioctl_wr   = 1'b1;
        ioctl_addr = a;
        ioctl_dout = d;
        if (accept) begin
            e.addr = a[15:0];
            e.data = d;
            e.cyc  = cyc + 1;
            sb_q.push_back(e);
        end
        tick();
        ioctl_wr = 1'b0;
    endtask

    // Counts edges after the fall until core_reset drops.
    task automatic wait_release(input string tag);
        int unsigned n = 0;
        while (core_reset && n < 20) begin
            tick();
            n++;
        end
        check_eq(tag, 64'(n), 64'(HOLD));
        check_eq({tag, "_busy"}, 64'(busy), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        RESET_N        = 1'b0;
        ioctl_download = 1'b0;
        ioctl_index    = 8'd0;
        ioctl_wr       = 1'b0;
        ioctl_addr     = 25'd0;
        ioctl_dout     = 8'd0;
        tick();
        tick();

        check_eq("rst_core_reset", 64'(core_reset), 64'd1);
        check_eq("rst_busy", 64'(busy), 64'd1);
        check_eq("rst_sw", sw, 64'hFFFF_FFFF_FFFF_FFFF);
        check_eq("rst_dn_wr", 64'(dn_wr), 64'd0);
        check_eq("rst_dn_addr", 64'(dn_addr), 64'd0);
        check_eq("rst_mod_valid", 64'(mod_valid), 64'd0);
        check_eq("rst_rom_len", 64'(rom_len), 64'd0);
        check_eq("rst_overflow", 64'(overflow), 64'd0);

        RESET_N = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            tick();
            check_eq("rst_hold_core_reset", 64'(core_reset), 64'(i < 4));
            check_eq("rst_hold_busy", 64'(busy), 64'(i < 4));
        end

        // ROM stream
        start_dl(8'd0);
        check_eq("rom_core_reset", 64'(core_reset), 64'd1);
        wr_byte(25'd0, 8'h01, 1'b1);
        wr_byte(25'd1, 8'h02, 1'b1);
        wr_byte(25'd2, 8'hFF, 1'b1);
        tick();
        check_eq("rom_len", 64'(rom_len), 64'd3);
        check_eq("rom_sum", 64'(rom_sum), 64'h0102);
        check_eq("rom_core_reset_mid", 64'(core_reset), 64'd1);
        end_dl();
        wait_release("rom_hold");

        // Overflow and top-of-range boundary
        start_dl(8'd0);
        wr_byte(25'd0, 8'h10, 1'b1);
        wr_byte(25'hC000, 8'h55, 1'b0);
        tick();
        check_eq("ovf_flag", 64'(overflow), 64'd1);
        check_eq("ovf_len", 64'(rom_len), 64'd1);
        check_eq("ovf_sum", 64'(rom_sum), 64'h10);
        wr_byte(25'h0BFFF, 8'h01, 1'b1);
        wr_byte(25'h1_0000, 8'h77, 1'b0);
        tick();
        check_eq("edge_len", 64'(rom_len), 64'hC000);
        check_eq("edge_sum", 64'(rom_sum), 64'h11);
        end_dl();
        wait_release("ovf_hold");

        // New ROM download clears stats; last strobe coincides with the fall
        start_dl(8'd0);
        check_eq("clr_overflow", 64'(overflow), 64'd0);
        check_eq("clr_len", 64'(rom_len), 64'd0);
        check_eq("clr_sum", 64'(rom_sum), 64'd0);
        ioctl_download = 1'b0;
        wr_byte(25'd5, 8'h07, 1'b1);
        check_eq("fall_len", 64'(rom_len), 64'd6);
        check_eq("fall_sum", 64'(rom_sum), 64'd7);
        wait_release("fall_hold");

        // Variant
        start_dl(8'd1);
        wr_byte(25'd1, 8'h22, 1'b0);
        check_eq("var_ignored", 64'(mod_valid), 64'd0);
        wr_byte(25'd0, 8'h0B, 1'b0);
        check_eq("var_mod", 64'(mod), 64'h0B);
        check_eq("var_valid", 64'(mod_valid), 64'd1);
        end_dl();
        wait_release("var_hold");

        // DIP switches; index change mid-download must not redirect bytes
        start_dl(8'd254);
        wr_byte(25'd3, 8'h5A, 1'b0);
        wr_byte(25'd9, 8'h00, 1'b0);
        ioctl_index = 8'd0;
        wr_byte(25'd20, 8'h33, 1'b0);
        check_eq("dip_sw", sw, 64'hFFFF_FFFF_5AFF_FFFF);
        end_dl();
        wait_release("dip_hold");

        // Re-trigger two cycles into HOLD
        start_dl(8'd0);
        wr_byte(25'd0, 8'h44, 1'b1);
        end_dl();
        tick();
        check_eq("retrig_gap1", 64'(core_reset), 64'd1);
        tick();
        check_eq("retrig_gap2", 64'(core_reset), 64'd1);
        start_dl(8'd254);
        check_eq("retrig_gap3", 64'(core_reset), 64'd1);
        wr_byte(25'd0, 8'hA5, 1'b0);
        check_eq("retrig_sw", sw, 64'hFFFF_FFFF_5AFF_FFA5);
        end_dl();
        wait_release("retrig_hold");

        // Reset in the middle of a ROM download
        start_dl(8'd0);
        wr_byte(25'd0, 8'h11, 1'b1);
        wr_byte(25'd1, 8'h22, 1'b1);
        tick();
        RESET_N = 1'b0;
        #1;
        check_eq("mid_rst_len", 64'(rom_len), 64'd0);
        check_eq("mid_rst_sum", 64'(rom_sum), 64'd0);
        check_eq("mid_rst_dn_wr", 64'(dn_wr), 64'd0);
        check_eq("mid_rst_core_reset", 64'(core_reset), 64'd1);
        check_eq("mid_rst_mod_valid", 64'(mod_valid), 64'd0);
        tick();
        RESET_N = 1'b1;
        wr_byte(25'd2, 8'h33, 1'b0);
        wr_byte(25'd3, 8'h44, 1'b0);
        check_eq("post_rst_core_reset", 64'(core_reset), 64'd1);
        for (int i = 0; i < 20 && core_reset; i++) tick();
        check_eq("post_rst_idle", 64'(busy), 64'd0);
        wr_byte(25'd4, 8'h55, 1'b0);
        tick();
        check_eq("stale_dl_ignored", 64'(core_reset), 64'd0);
        check_eq("stale_len", 64'(rom_len), 64'd0);
        end_dl();
        start_dl(8'd0);
        wr_byte(25'd7, 8'h66, 1'b1);
        tick();
        check_eq("new_dl_len", 64'(rom_len), 64'd8);
        end_dl();
        wait_release("final_hold");

        tick();
        check_eq("sb_empty", 64'(sb_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
